alu_cmd_dispatcher: RTL and testbench

Command-queue stage directly upstream of the cascaded ALU. Accepts operand/opcode commands over a valid/ready interface, buffers up to DEPTH of them, and issues them one at a time to the ALU using its start_op/end_op handshake. Returns each ALU result, tagged with its opcode and a timeout flag, over a valid/ready response interface. All state is clocked on one clock with asynchronous active-high reset.

---
 rtl/alu_cmd_dispatcher.sv | 172 +++++++++++++++++
 tb/tb_alu_cmd_dispatcher.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_dispatcher.sv
// Command FIFO plus single-outstanding issue FSM in front of the cascaded ALU.
// Commands issue in acceptance order. Each one finishes on end_op or on timeout and returns one tagged response.
module alu_cmd_dispatcher #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 16,
    parameter int DEPTH        = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [DATA_WIDTH-1:0]        cmd_a,
    input  logic [DATA_WIDTH-1:0]        cmd_b,
    input  logic [2:0]                   cmd_op,
    output logic                         start_op,
    output logic [DATA_WIDTH-1:0]        A,
    output logic [DATA_WIDTH-1:0]        B,
    output logic [2:0]                   op_sel,
    input  logic [RESULT_WIDTH-1:0]      result,
    input  logic                         end_op,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [RESULT_WIDTH-1:0]      rsp_result,
    output logic [2:0]                   rsp_op,
    output logic                         rsp_timeout,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         spurious_end
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int EW = 2*DATA_WIDTH + 3;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT-2);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

    state_t                  r_state;
    logic [EW-1:0]           r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [TW-1:0]           r_tcnt;
    logic                    r_start;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [2:0]              r_op;
    logic                    r_rsp_valid;
    logic [RESULT_WIDTH-1:0] r_rsp_result;
    logic [2:0]              r_rsp_op;
    logic                    r_rsp_timeout;
    logic                    r_spurious;

    logic                    w_push;
    logic                    w_pop;
    logic [EW-1:0]           w_head;
    logic [DATA_WIDTH-1:0]   w_head_a;
    logic [DATA_WIDTH-1:0]   w_head_b;
    logic [2:0]              w_head_op;

    // Readiness depends only on registered occupancy, so a same-cycle pop never frees a slot.
    assign cmd_ready = (r_count < FULL) && !rst;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);

    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_op = w_head[EW-1 -: 3];
    assign w_head_a  = w_head[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign w_head_b  = w_head[DATA_WIDTH-1:0];

    assign start_op     = r_start;
    assign A            = r_a;
    assign B            = r_b;
    assign op_sel       = r_op;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_op       = r_rsp_op;
    assign rsp_timeout  = r_rsp_timeout;
    assign fifo_count   = r_count;
    assign spurious_end = r_spurious;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_tcnt        <= '0;
            r_start       <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_op      <= '0;
            r_rsp_timeout <= 1'b0;
            r_spurious    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (end_op) begin
                        r_spurious <= 1'b1;
                    end
                    if (w_pop) begin
                        r_a     <= w_head_a;
                        r_b     <= w_head_b;
                        r_op    <= w_head_op;
                        r_start <= 1'b1;
                        r_tcnt  <= '0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // end_op is tested first so it wins over a coincident timeout.
                    if (end_op) begin
                        r_rsp_result  <= result;
                        r_rsp_op      <= r_op;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_start       <= 1'b0;
                        r_state       <= ST_RESP;
                    end else if (r_tcnt == TO_LAST) begin
                        r_rsp_result  <= '0;
                        r_rsp_op      <= r_op;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_start       <= 1'b0;
                        r_state       <= ST_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (end_op) begin
                        r_spurious <= 1'b1;
                    end
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_dispatcher.sv
// Directed self-checking bench for alu_cmd_dispatcher with a behavioural ALU responder.
module tb_alu_cmd_dispatcher;

    localparam int TO = 64;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_op;
    logic        start_op;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op_sel;
    logic [15:0] result;
    logic        end_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_timeout;
    logic [2:0]  fifo_count;
    logic        spurious_end;

    // ALU model controls and forced-pulse inputs
    logic        alu_en;
    int          alu_delay;
    logic        ovr_en;
    logic [15:0] ovr_res;
    logic        m_end;
    logic [15:0] m_res;
    int          m_cnt;
    logic        f_end;
    logic [15:0] f_res;

    int checks;
    int errors;

    assign end_op = m_end | f_end;
    assign result = f_end ? f_res : m_res;

    alu_cmd_dispatcher #(
        .DATA_WIDTH  (8),
        .RESULT_WIDTH(16),
        .DEPTH       (4),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .start_op    (start_op),
        .A           (A),
        .B           (B),
        .op_sel      (op_sel),
        .result      (result),
        .end_op      (end_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_op      (rsp_op),
        .rsp_timeout (rsp_timeout),
        .fifo_count  (fifo_count),
        .spurious_end(spurious_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responds alu_delay cycles after start_op rises: end_op is sampled on edge S+alu_delay.
    always @(negedge clk) begin
        m_end = 1'b0;
        if (start_op && alu_en) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == alu_delay) begin
                m_end = 1'b1;
                m_res = ovr_en ? ovr_res : ({8'h00, A} + {8'h00, B});
            end
        end else begin
            m_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_accept cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({start_op, A, B, op_sel} !== 20'h0) begin
            errors++;
            $display("FAIL reset_issue_outs got %h required 0", {start_op, A, B, op_sel});
        end
        checks++;
        if ({rsp_valid, rsp_result, rsp_op, rsp_timeout} !== 21'h0) begin
            errors++;
            $display("FAIL reset_rsp_outs got %h required 0", {rsp_valid, rsp_result, rsp_op, rsp_timeout});
        end
        checks++;
        if ({fifo_count, spurious_end, cmd_ready} !== 5'h0) begin
            errors++;
            $display("FAIL reset_misc got count=%0d spur=%0b ready=%0b required 0", fifo_count, spurious_end, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %0b required 1", cmd_ready);
        end
    endtask

    task automatic test_single_op();
        alu_en    = 1'b1;
        alu_delay = 3;
        rsp_ready = 1'b0;
        push(8'h05, 8'h03, 3'b001);
        checks++;
        if (fifo_count !== 3'd1 || start_op !== 1'b0) begin
            errors++;
            $display("FAIL single_accept count=%0d start=%0b required 1/0", fifo_count, start_op);
        end
        tick();
        checks++;
        if (start_op !== 1'b1 || A !== 8'h05 || B !== 8'h03 || op_sel !== 3'b001 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL single_issue start=%0b A=%h B=%h op=%0d count=%0d required 1/05/03/1/0", start_op, A, B, op_sel, fifo_count);
        end
        tick();
        tick();
        checks++;
        if (start_op !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_hold start=%0b rsp_valid=%0b required 1/0", start_op, rsp_valid);
        end
        tick();
        checks++;
        if (start_op !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 16'h0008 || rsp_op !== 3'b001 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp start=%0b valid=%0b res=%h op=%0d to=%0b required 0/1/0008/1/0", start_op, rsp_valid, rsp_result, rsp_op, rsp_timeout);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h0008 || A !== 8'h05 || op_sel !== 3'b001) begin
            errors++;
            $display("FAIL single_rsp_stable valid=%0b res=%h A=%h op_sel=%0d required 1/0008/05/1", rsp_valid, rsp_result, A, op_sel);
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || start_op !== 1'b0) begin
            errors++;
            $display("FAIL single_consume valid=%0b start=%0b required 0/0", rsp_valid, start_op);
        end
    endtask

    task automatic test_fill_backpressure();
        logic accepted;
        alu_en    = 1'b1;
        alu_delay = 2;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(8'(8'h10 + i), 8'(8'h20 + i), 3'(i));
        end
        checks++;
        if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full count=%0d ready=%0b required 4/0", fifo_count, cmd_ready);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_op !== 3'd0) begin
            errors++;
            $display("FAIL fill_inflight valid=%0b op=%0d required 1/0", rsp_valid, rsp_op);
        end
        cmd_valid = 1'b1;
        cmd_a     = 8'h15;
        cmd_b     = 8'h25;
        cmd_op    = 3'd5;
        rsp_ready = 1'b1;
        accepted  = 1'b0;
        fork
            begin
                int n;
                n = 0;
                while (!accepted && n < 300) begin
                    @(negedge clk);
                    if (cmd_ready) begin
                        @(posedge clk);
                        #1;
                        cmd_valid = 1'b0;
                        accepted  = 1'b1;
                    end
                    n++;
                end
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    wait_rsp();
                    checks++;
                    if (rsp_valid !== 1'b1 || rsp_result !== 16'(16'h30 + 2*k) || rsp_op !== 3'(k) || rsp_timeout !== 1'b0) begin
                        errors++;
                        $display("FAIL fill_rsp%0d valid=%0b res=%h op=%0d to=%0b required 1/%h/%0d/0", k, rsp_valid, rsp_result, rsp_op, rsp_timeout, 16'(16'h30 + 2*k), k);
                    end
                    tick();
                end
            end
        join
        checks++;
        if (accepted !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL fill_sixth accepted=%0b count=%0d required 1/0", accepted, fifo_count);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_timeout();
        alu_en    = 1'b0;
        rsp_ready = 1'b0;
        push(8'h11, 8'h22, 3'd3);
        push(8'h01, 8'h02, 3'd5);
        checks++;
        if (start_op !== 1'b1 || A !== 8'h11 || fifo_count !== 3'd1) begin
            errors++;
            $display("FAIL to_issue start=%0b A=%h count=%0d required 1/11/1", start_op, A, fifo_count);
        end
        for (int i = 0; i < TO - 2; i++) begin
            tick();
        end
        checks++;
        if (rsp_valid !== 1'b0 || start_op !== 1'b1) begin
            errors++;
            $display("FAIL to_early valid=%0b start=%0b required 0/1", rsp_valid, start_op);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_result !== 16'h0000 || rsp_op !== 3'd3 || start_op !== 1'b0) begin
            errors++;
            $display("FAIL to_rsp valid=%0b to=%0b res=%h op=%0d start=%0b required 1/1/0000/3/0", rsp_valid, rsp_timeout, rsp_result, rsp_op, start_op);
        end
        alu_en    = 1'b1;
        alu_delay = 2;
        rsp_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (start_op !== 1'b1 || A !== 8'h01 || B !== 8'h02 || op_sel !== 3'd5) begin
            errors++;
            $display("FAIL to_next_issue start=%0b A=%h B=%h op=%0d required 1/01/02/5", start_op, A, B, op_sel);
        end
        wait_rsp();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h0003 || rsp_timeout !== 1'b0 || rsp_op !== 3'd5) begin
            errors++;
            $display("FAIL to_next_rsp valid=%0b res=%h to=%0b op=%0d required 1/0003/0/5", rsp_valid, rsp_result, rsp_timeout, rsp_op);
        end
        tick();
    endtask

    task automatic test_race();
        alu_en    = 1'b1;
        alu_delay = TO - 1;
        ovr_en    = 1'b1;
        ovr_res   = 16'hBEEF;
        rsp_ready = 1'b0;
        push(8'h07, 8'h09, 3'd6);
        tick();
        for (int i = 0; i < TO - 2; i++) begin
            tick();
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL race_early valid=%0b required 0", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'hBEEF || rsp_timeout !== 1'b0 || rsp_op !== 3'd6) begin
            errors++;
            $display("FAIL race_rsp valid=%0b res=%h to=%0b op=%0d required 1/BEEF/0/6", rsp_valid, rsp_result, rsp_timeout, rsp_op);
        end
        rsp_ready = 1'b1;
        tick();
        ovr_en = 1'b0;
    endtask

    task automatic test_spurious();
        checks++;
        if (spurious_end !== 1'b0) begin
            errors++;
            $display("FAIL spur_pre got %0b required 0", spurious_end);
        end
        @(negedge clk);
        f_res = 16'h1234;
        f_end = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (spurious_end !== 1'b1 || rsp_valid !== 1'b0 || fifo_count !== 3'd0 || start_op !== 1'b0) begin
            errors++;
            $display("FAIL spur_set spur=%0b valid=%0b count=%0d start=%0b required 1/0/0/0", spurious_end, rsp_valid, fifo_count, start_op);
        end
        @(negedge clk);
        f_end = 1'b0;
        tick();
        tick();
        checks++;
        if (spurious_end !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL spur_sticky spur=%0b valid=%0b required 1/0", spurious_end, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        alu_en    = 1'b0;
        rsp_ready = 1'b0;
        push(8'h30, 8'h01, 3'd1);
        push(8'h31, 8'h01, 3'd2);
        push(8'h32, 8'h01, 3'd3);
        checks++;
        if (start_op !== 1'b1 || fifo_count !== 3'd2) begin
            errors++;
            $display("FAIL rmid_pre start=%0b count=%0d required 1/2", start_op, fifo_count);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (start_op !== 1'b0 || fifo_count !== 3'd0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || spurious_end !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async start=%0b count=%0d valid=%0b ready=%0b spur=%0b required all 0", start_op, fifo_count, rsp_valid, cmd_ready, spurious_end);
        end
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        alu_en    = 1'b1;
        alu_delay = 3;
        push(8'h40, 8'h02, 3'd7);
        tick();
        checks++;
        if (start_op !== 1'b1 || A !== 8'h40 || op_sel !== 3'd7) begin
            errors++;
            $display("FAIL rmid_reissue start=%0b A=%h op=%0d required 1/40/7", start_op, A, op_sel);
        end
        wait_rsp();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h0042 || rsp_op !== 3'd7 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rmid_rsp valid=%0b res=%h op=%0d to=%0b required 1/0042/7/0", rsp_valid, rsp_result, rsp_op, rsp_timeout);
        end
        rsp_ready = 1'b1;
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        rsp_ready = 1'b0;
        alu_en    = 1'b0;
        alu_delay = 3;
        ovr_en    = 1'b0;
        ovr_res   = '0;
        m_end     = 1'b0;
        m_res     = '0;
        m_cnt     = 0;
        f_end     = 1'b0;
        f_res     = '0;

        test_reset();
        test_single_op();
        test_fill_backpressure();
        test_timeout();
        test_race();
        test_spurious();
        test_reset_mid_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
